// File: rtl/dlx_pkg.sv
// dlx_pkg: DLX opcode/func constants, instruction format and encoder FSM enums
// Shared by instr_encoder and control_logic.
package dlx_pkg;
  localparam logic [5:0] ALU_OP = 6'h00;
  localparam logic [5:0] FPU_OP = 6'h01;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQZ   = 6'h04;
  localparam logic [5:0] BNEZ   = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SUBI   = 6'h0a;
  localparam logic [5:0] ANDI   = 6'h0c;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_INV} fmt_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x W synchronous FIFO holding encoded words
// push/wdata write side, pop/rdata read side (rdata is the head, 0 when empty),
// full/empty/count status; count is registered so status changes a cycle after the event.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rdata = empty ? '0 : mem[rp];
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded DLX fields into R/I/J words and streams them into instruction memory
// Host side: start/start_addr open a session, in_* valid/ready bundle stream, in_last ends it.
// Memory side: imem_wr_en/imem_ready handshake with imem_addr/imem_wdata (bit 0 = MSB).
// Status: word_count, busy, done pulse, err_invalid pulse, err_sticky.
module instr_encoder
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [0:5]        in_opcode,
  input  logic [0:4]        in_rs1,
  input  logic [0:4]        in_rs2,
  input  logic [0:4]        in_rd,
  input  logic [0:5]        in_func,
  input  logic [0:25]       in_imm,
  input  logic              in_last,
  output logic              imem_wr_en,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [0:31]       imem_wdata,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err_invalid,
  output logic              err_sticky
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state, nxt;
  fmt_e fmt;
  logic hs, bad, push, wr, go, full, empty;
  logic [CW-1:0] fifo_count;
  logic [31:0] enc, head;
  assign fmt = fmt_e'(in_fmt);
  assign hs = in_valid && in_ready;
  assign bad = fmt == FMT_INV || (fmt == FMT_R && in_opcode != ALU_OP && in_opcode != FPU_OP);
  assign push = hs && !bad && !full;
  assign wr = imem_wr_en && imem_ready;
  assign go = state == S_IDLE && start;
  assign in_ready = state == S_LOAD && fifo_count < CW'(DEPTH);
  assign imem_wr_en = !empty && (state == S_LOAD || state == S_DRAIN);
  assign imem_wdata = head;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_comb
    enc = fmt == FMT_R ? {in_opcode, in_rs1, in_rs2, in_rd, 5'b0, in_func}
        : fmt == FMT_I ? {in_opcode, in_rs1, in_rd, in_imm[10:25]}
        : {in_opcode, in_imm};
  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(wr),
    .wdata(enc),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = (hs && in_last) ? S_DRAIN : S_LOAD;
      S_DRAIN: nxt = empty ? S_DONE : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      imem_addr <= '0;
      word_count <= '0;
      err_invalid <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= nxt;
      err_invalid <= hs && bad;
      err_sticky <= !go && (err_sticky || (hs && bad));
      if (go) begin
        imem_addr <= start_addr;
        word_count <= '0;
      end else if (wr) begin
        imem_addr <= imem_addr + ADDR_W'(4);
        word_count <= word_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a field-level model
module tb_instr_encoder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, imem_ready = 1'b0;
  logic [31:0] start_addr = '0;
  logic [1:0] in_fmt = '0;
  logic [5:0] in_opcode = '0, in_func = '0;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [25:0] in_imm = '0;
  logic in_ready, imem_wr_en, busy, done, err_invalid, err_sticky;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;
  int n_chk = 0, n_fail = 0, done_cnt = 0, err_cnt = 0, exp_err = 0, n_push = 0, cyc = 0;
  logic [63:0] exp_q[$];
  int wr_cyc[$], acc_cyc[$];
  logic [31:0] base = '0, last_addr = '0, last_data = '0;
  bit rnd_ready = 0;

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_imm(in_imm),
    .in_last(in_last), .imem_wr_en(imem_wr_en), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .busy(busy), .done(done),
    .err_invalid(err_invalid), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rnd_ready) begin #1; imem_ready = 1'($urandom_range(0, 1)); end

  function automatic logic [31:0] enc_m(input int f, op, rs1, rs2, rd, func, imm);
    longint w;
    longint op_v = longint'(op) * 67108864;
    if (f == 0) w = op_v + longint'(rs1) * 2097152 + longint'(rs2) * 65536 + longint'(rd) * 2048 + func;
    else if (f == 1) w = op_v + longint'(rs1) * 2097152 + longint'(rd) * 65536 + (imm % 65536);
    else w = op_v + (imm % 67108864);
    return w[31:0];
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (done) done_cnt++;
    if (err_invalid) err_cnt++;
    if (imem_wr_en && imem_ready) begin
      logic [63:0] e;
      n_chk++;
      wr_cyc.push_back(cyc);
      last_addr = imem_addr;
      last_data = imem_wdata;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write addr/data got=%h_%h exp=%h_%h", imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    n_chk++;
    if ({in_ready, imem_wr_en, imem_addr, imem_wdata, word_count, busy, done, err_invalid, err_sticky} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs not zero: rdy=%b wr=%b addr=%h data=%h cnt=%h busy=%b done=%b ei=%b es=%b exp all 0",
               name, in_ready, imem_wr_en, imem_addr, imem_wdata, word_count, busy, done, err_invalid, err_sticky);
    end
  endtask

  task automatic start_session(input logic [31:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    base = a;
    n_push = 0;
    exp_err = 0;
    err_cnt = 0;
    n_chk++;
    if (busy !== 1'b1 || err_sticky !== 1'b0 || word_count !== '0 || imem_addr !== a) begin
      n_fail++;
      $display("FAIL start busy=%b sticky=%b cnt=%0d addr=%h exp 1 0 0 %h", busy, err_sticky, word_count, imem_addr, a);
    end
  endtask

  task automatic send(input int f, op, rs1, rs2, rd, func, imm, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_fmt = f[1:0];
    in_opcode = op[5:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_rd = rd[4:0];
    in_func = func[5:0];
    in_imm = imm[25:0];
    in_last = last;
    forever begin
      @(negedge clk);
      t++;
      if (in_ready === 1'b1 || t >= 300) break;
      @(posedge clk); #1;
    end
    if (in_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout in_ready=%b exp 1", in_ready);
    end else begin
      acc_cyc.push_back(cyc);
      if (f == 3 || (f == 0 && op > 1)) exp_err++;
      else begin
        exp_q.push_back({base + 32'(4 * n_push), enc_m(f, op, rs1, rs2, rd, func, imm)});
        n_push++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (t < 500) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) break;
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout done=%b exp 1", done);
    end
    n_chk++;
    if (word_count !== 16'(n_push) || imem_addr !== base + 32'(4 * n_push) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final cnt=%0d addr=%h pending=%0d exp %0d %h 0", word_count, imem_addr, exp_q.size(),
               n_push, base + 32'(4 * n_push));
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse done=%b busy=%b exp 0 0", done, busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if (err_cnt != exp_err || err_sticky !== (exp_err > 0)) begin
      n_fail++;
      $display("FAIL errors pulses=%0d sticky=%b exp %0d %b", err_cnt, err_sticky, exp_err, exp_err > 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle_after_reset");
  endtask

  task automatic test_addi();
    imem_ready = 1'b1;
    start_session(32'h100);
    send(1, 8, 2, 0, 1, 0, 5, 1);
    wait_done();
    n_chk++;
    if (last_addr !== 32'h100 || last_data !== 32'h20410005 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL addi addr=%h data=%h cnt=%0d exp 100 20410005 1", last_addr, last_data, word_count);
    end
  endtask

  task automatic test_r_j();
    imem_ready = 1'b1;
    start_session(32'h2000);
    send(0, 0, 1, 2, 3, 'h20, 0, 0);
    start = 1'b1;
    start_addr = 32'h5000;
    @(posedge clk); #1;
    start = 1'b0;
    send(2, 2, 0, 0, 0, 0, 'h100, 1);
    wait_done();
    n_chk++;
    if (last_addr !== 32'h2004 || last_data !== 32'h08000100) begin
      n_fail++;
      $display("FAIL r_j last addr=%h data=%h exp 2004 08000100", last_addr, last_data);
    end
  endtask

  task automatic test_backpressure();
    imem_ready = 1'b0;
    start_session(32'h300);
    for (int i = 0; i < 4; i++) send(1, 8 + i, i, 0, i + 1, 0, i * 3, 0);
    n_chk++;
    if (in_ready !== 1'b0 || imem_wr_en !== 1'b1 || imem_addr !== 32'h300 || word_count !== '0) begin
      n_fail++;
      $display("FAIL full rdy=%b wr=%b addr=%h cnt=%0d exp 0 1 300 0", in_ready, imem_wr_en, imem_addr, word_count);
    end
    fork
      begin
        repeat (8) @(posedge clk);
        #1;
        imem_ready = 1'b1;
      end
    join_none
    send(1, 12, 7, 0, 8, 0, 'hbeef, 0);
    send(2, 3, 0, 0, 0, 0, 'h3ffffff, 1);
    wait_done();
  endtask

  task automatic test_back_to_back();
    imem_ready = 1'b1;
    start_session(32'h800);
    wr_cyc.delete();
    acc_cyc.delete();
    for (int i = 0; i < 5; i++) send(1, 13, i, 0, i, 0, 100 + i, i == 4);
    wait_done();
    n_chk++;
    if (wr_cyc.size() != 5 || acc_cyc.size() != 5 || wr_cyc[0] != acc_cyc[0] + 1) begin
      n_fail++;
      $display("FAIL latency writes=%0d first_wr=%0d exp 5 at %0d", wr_cyc.size(),
               wr_cyc.size() > 0 ? wr_cyc[0] : -1, acc_cyc.size() > 0 ? acc_cyc[0] + 1 : -1);
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_chk++;
        if (wr_cyc[i] != wr_cyc[i-1] + 1) begin
          n_fail++;
          $display("FAIL throughput write %0d cycle=%0d exp %0d", i, wr_cyc[i], wr_cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_invalid();
    imem_ready = 1'b1;
    start_session(32'h400);
    send(3, 8, 1, 2, 3, 4, 5, 0);
    send(0, 8, 1, 2, 3, 'h20, 0, 1);
    wait_done();
    start_session(32'h500);
    send(1, 8, 4, 0, 5, 0, 'h1234, 1);
    wait_done();
  endtask

  task automatic test_wrap();
    imem_ready = 1'b1;
    start_session(32'hFFFFFFFC);
    send(1, 8, 1, 0, 1, 0, 1, 0);
    send(1, 8, 1, 0, 1, 0, 2, 1);
    wait_done();
    n_chk++;
    if (last_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap last addr=%h exp 00000000", last_addr);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    imem_ready = 1'b0;
    start_session(32'h600);
    for (int i = 0; i < 3; i++) send(2, 2, 0, 0, 0, 0, i + 1, 0);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (done_cnt != d0 || busy !== 1'b0 || imem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort done_pulses=%0d busy=%b wr=%b exp %0d 0 0", done_cnt - d0, busy, imem_wr_en, 0);
    end
    start_session(32'h700);
    send(1, 8, 2, 0, 1, 0, 5, 1);
    wait_done();
  endtask

  task automatic test_random();
    rnd_ready = 1;
    for (int s = 0; s < 4; s++) begin
      int n = $urandom_range(1, 9);
      start_session($urandom & 32'hFFFFFFFC);
      for (int k = 0; k < n; k++) begin
        int f = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
        int op = (f == 0 && $urandom_range(0, 3) != 0) ? $urandom_range(0, 1) : $urandom_range(0, 63);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(f, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 63), $urandom_range(0, 67108863), k == n - 1);
      end
      wait_done();
    end
    rnd_ready = 0;
    @(posedge clk); #1;
    imem_ready = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_addi();
    test_r_j();
    test_backpressure();
    test_back_to_back();
    test_invalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
